uriscv_irq_ctrl: RTL and testbench
==================================

Name: uriscv_irq_ctrl

Overview:
External interrupt controller in front of the uriscv CSR unit's machine external interrupt input. It synchronises NUM_SRC asynchronous sources, latches them as level or edge pending bits, and picks the lowest-numbered enabled pending source (fixed priority). It drives intr_o and isr_vector_o to the CSR block and sequences a claim/complete handshake over a small memory-mapped register port, with one source in service at a time and no nesting.

Parameters:
NUM_SRC, 8, number of interrupt sources, 1..31; source index i has ID i+1, and ID 0 means none.
VECTOR_BASE, 32'h0000_0100, isr_vector_o base; vector = VECTOR_BASE + (ID << 2).

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
src_i  in  NUM_SRC  asynchronous interrupt sources, active-high
reg_valid_i  in  1  register access strobe, single cycle, no wait states
reg_we_i  in  1  1 = write, 0 = read
reg_addr_i  in  5  byte address; bits [4:2] decoded, bits [1:0] ignored
reg_wdata_i  in  32  write data
reg_rdata_o  out  32  read data, combinational, valid in the same cycle as reg_valid_i
intr_o  out  1  interrupt request to the CSR unit, registered
isr_vector_o  out  32  vector of the requested ID, registered
in_service_o  out  1  a claimed source awaits completion

Behaviour:
- Reset, rst_i sampled high at a clock edge: all flops are cleared. intr_o=0, in_service_o=0, isr_vector_o=VECTOR_BASE, state=IDLE. Pending, enable, edge_sel and in_service_id are all 0.
- Synchroniser: src_i passes through 2 flops (s1, s2), then s3 holds the previous s2 for edge detection.
- Pending, edge source (edge_sel[i]=1): set when s2 & ~s3. Cleared by a claim of that ID or by W1C to PENDING. If set and clear fall in the same cycle, set wins.
- Pending, level source: pend[i] = s2[i] registered. It is forced to 0 while i+1 == in_service_id. W1C has no effect on it.
- Arbitration (combinational): best_id = lowest ID with pend & enable set, else 0.
- Register map, 32-bit, bits at or above NUM_SRC read 0:
  0x00 PENDING: read gives pend; write is W1C for edge sources.
  0x04 ENABLE: RW.
  0x08 EDGE_SEL: RW.
  0x0C CLAIM: read has side effects (see FSM); a write is COMPLETE, taking ID from wdata[4:0].
  0x10 STATUS: RO, {26'b0, in_service_o, in_service_id[4:0]}.
  Addresses 0x14..0x1C read 0 and ignore writes.
- FSM:
  IDLE: if best_id != 0, go to REQ; intr_o<=1 and isr_vector_o<=VECTOR_BASE+(best_id<<2).
  REQ: isr_vector_o tracks best_id every cycle.
    If best_id becomes 0 (enable cleared or W1C), go to IDLE with intr_o<=0.
    A CLAIM read returns best_id in the same cycle. The claimed edge pending bit clears, in_service_id<=best_id, state goes to SERVICE, and next cycle intr_o<=0 and in_service_o<=1.
  SERVICE: a COMPLETE write whose wdata[4:0]==in_service_id goes to IDLE; in_service_o<=0 and in_service_id<=0. A mismatched COMPLETE is ignored.
- CLAIM read in IDLE or SERVICE returns 0 with no side effects. COMPLETE outside SERVICE is ignored.
- Latency: from the first edge at which src_i is sampled high to intr_o=1 is 4 rising edges (s1, s2, pend, intr_o).
- A level source still high after COMPLETE re-requests: pend is set on the next edge, then intr_o the edge after that.
- Disabled sources still latch pending and are visible in PENDING.
- ENABLE, EDGE_SEL, W1C and COMPLETE writes take effect on the clock edge that samples them. The arbitration result reflects them from the following cycle.

Test Plan:
- Reset then ENABLE=0x01, EDGE_SEL=0x01; pulse src_i[0] for 1 cycle -> intr_o=1 exactly 4 edges after the pulse is sampled, isr_vector_o=0x104, PENDING=0x01.
- src_i[2] and src_i[5] pending together (both edge, enabled) -> CLAIM returns 3, PENDING=0x20. COMPLETE 3 -> intr_o re-asserts with isr_vector_o=0x118. CLAIM then returns 6.
- Level source 1 (ENABLE=0x02, EDGE_SEL=0) held high -> CLAIM returns 2 and PENDING bit1=0 while in service. COMPLETE 2 with src still high -> intr_o back to 1 two edges later.
- Edge on src_i[0] arrives the same cycle as W1C of bit0 -> PENDING bit0 remains 1. While in REQ, ENABLE write 0 -> intr_o=0 next edge and state IDLE.
- In SERVICE with in_service_id=1, COMPLETE 4 -> ignored, STATUS=0x21. A CLAIM read in SERVICE returns 0 and PENDING is unchanged.
- Assert rst_i for 1 cycle while in SERVICE -> next edge: intr_o=0, in_service_o=0, isr_vector_o=0x100, all registers read 0.

Source files
------------

// File: rtl/uriscv_irq_ctrl.sv
// uriscv external interrupt controller: sync, pending latch,
// fixed-priority arbitration and claim/complete sequencing.
module uriscv_irq_ctrl #(
  parameter int unsigned NUM_SRC     = 8,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0100
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               reg_valid_i,
  input  logic               reg_we_i,
  input  logic [4:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               intr_o,
  output logic [31:0]        isr_vector_o,
  output logic               in_service_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  localparam logic [2:0] A_PEND  = 3'd0;
  localparam logic [2:0] A_EN    = 3'd1;
  localparam logic [2:0] A_EDGE  = 3'd2;
  localparam logic [2:0] A_CLAIM = 3'd3;
  localparam logic [2:0] A_STAT  = 3'd4;

  state_t state_q, state_d;

  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] enable_q, edge_q;
  logic [NUM_SRC-1:0] rise, w1c_mask;
  logic [NUM_SRC-1:0] claim_mask, svc_mask;

  logic [4:0]  svc_id_q, svc_id_d;
  logic [4:0]  best_id;
  logic        intr_q, intr_d;
  logic        insvc_q, insvc_d;
  logic [31:0] vec_q, vec_d;

  logic [2:0] sel;
  logic       rd_en, wr_en;
  logic       claim_hit, complete_hit;
  logic       unused_bits;

  assign sel   = reg_addr_i[4:2];
  assign rd_en = reg_valid_i & ~reg_we_i;
  assign wr_en = reg_valid_i & reg_we_i;

  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i[31:NUM_SRC]};

  function automatic logic [31:0] vec_of(input logic [4:0] id);
    return VECTOR_BASE + {25'd0, id, 2'b00};
  endfunction

  // descending scan so the lowest ID overwrites last
  always_comb begin
    best_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_q[i] && enable_q[i]) begin
        best_id = 5'(i + 1);
      end
    end
  end

  assign claim_hit = rd_en && (sel == A_CLAIM)
                  && (state_q == REQ) && (best_id != '0);

  assign complete_hit = wr_en && (sel == A_CLAIM)
                     && (state_q == SERVICE)
                     && (reg_wdata_i[4:0] == svc_id_q);

  always_comb begin
    claim_mask = '0;
    svc_mask   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_mask[i] = claim_hit && (best_id == 5'(i + 1));
      svc_mask[i]   = (svc_id_q == 5'(i + 1));
    end
  end

  assign rise = s2_q & ~s3_q;

  assign w1c_mask = (wr_en && (sel == A_PEND))
                  ? (reg_wdata_i[NUM_SRC-1:0] & edge_q)
                  : '0;

  // edge: set beats clear; level: follows s2 unless in service
  assign pend_d =
      (edge_q & ((pend_q & ~(w1c_mask | claim_mask)) | rise))
    | (~edge_q & s2_q & ~svc_mask);

  always_comb begin
    state_d  = state_q;
    intr_d   = intr_q;
    vec_d    = vec_q;
    insvc_d  = insvc_q;
    svc_id_d = svc_id_q;
    unique case (state_q)
      IDLE: begin
        if (best_id != '0) begin
          state_d = REQ;
          intr_d  = 1'b1;
          vec_d   = vec_of(best_id);
        end
      end
      REQ: begin
        if (best_id == '0) begin
          state_d = IDLE;
          intr_d  = 1'b0;
        end else if (claim_hit) begin
          state_d  = SERVICE;
          intr_d   = 1'b0;
          insvc_d  = 1'b1;
          svc_id_d = best_id;
        end else begin
          vec_d = vec_of(best_id);
        end
      end
      SERVICE: begin
        if (complete_hit) begin
          state_d  = IDLE;
          insvc_d  = 1'b0;
          svc_id_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      pend_q   <= '0;
      enable_q <= '0;
      edge_q   <= '0;
      svc_id_q <= '0;
      intr_q   <= 1'b0;
      insvc_q  <= 1'b0;
      vec_q    <= VECTOR_BASE;
    end else begin
      state_q  <= state_d;
      s1_q     <= src_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      pend_q   <= pend_d;
      svc_id_q <= svc_id_d;
      intr_q   <= intr_d;
      insvc_q  <= insvc_d;
      vec_q    <= vec_d;
      if (wr_en && (sel == A_EN)) begin
        enable_q <= reg_wdata_i[NUM_SRC-1:0];
      end
      if (wr_en && (sel == A_EDGE)) begin
        edge_q <= reg_wdata_i[NUM_SRC-1:0];
      end
    end
  end

  always_comb begin
    reg_rdata_o = '0;
    if (rd_en) begin
      unique case (sel)
        A_PEND:  reg_rdata_o = 32'(pend_q);
        A_EN:    reg_rdata_o = 32'(enable_q);
        A_EDGE:  reg_rdata_o = 32'(edge_q);
        A_CLAIM: reg_rdata_o = (state_q == REQ)
                             ? 32'(best_id) : '0;
        A_STAT:  reg_rdata_o = {26'd0, insvc_q, svc_id_q};
        default: reg_rdata_o = '0;
      endcase
    end
  end

  assign intr_o       = intr_q;
  assign isr_vector_o = vec_q;
  assign in_service_o = insvc_q;

endmodule

// File: tb/tb_uriscv_irq_ctrl.sv
// Directed bench for uriscv_irq_ctrl: register table plus
// hand-timed interrupt sequences.
module tb_uriscv_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src = '0;
  logic        reg_valid = 1'b0;
  logic        reg_we = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        intr;
  logic [31:0] vec;
  logic        insvc;

  int n_cmp = 0;
  int n_bad = 0;

  uriscv_irq_ctrl #(
    .NUM_SRC(8),
    .VECTOR_BASE(32'h0000_0100)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .src_i(src),
    .reg_valid_i(reg_valid),
    .reg_we_i(reg_we),
    .reg_addr_i(reg_addr),
    .reg_wdata_i(reg_wdata),
    .reg_rdata_o(reg_rdata),
    .intr_o(intr),
    .isr_vector_o(vec),
    .in_service_o(insvc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_valid = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(posedge clk);
    #1;
    reg_valid = 1'b0;
    reg_we    = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    reg_valid = 1'b1;
    reg_we    = 1'b0;
    reg_addr  = a;
    #1 d = reg_rdata;
    check(name, d, exp);
    @(posedge clk);
    #1;
    reg_valid = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    src = m;
    @(negedge clk);
    src = '0;
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{1'b1, 5'h04, 32'hFFFF_FFFF}, '{1'b0, 5'h04, 32'h0000_00FF},
      '{1'b1, 5'h08, 32'h0000_00A5}, '{1'b0, 5'h08, 32'h0000_00A5},
      '{1'b0, 5'h0B, 32'h0000_00A5}, '{1'b0, 5'h05, 32'h0000_00FF},
      '{1'b1, 5'h14, 32'hFFFF_FFFF}, '{1'b0, 5'h14, 32'h0},
      '{1'b0, 5'h18, 32'h0},         '{1'b0, 5'h1C, 32'h0},
      '{1'b1, 5'h10, 32'h0000_00FF}, '{1'b0, 5'h10, 32'h0},
      '{1'b0, 5'h00, 32'h0},         '{1'b0, 5'h0C, 32'h0},
      '{1'b1, 5'h04, 32'h0},         '{1'b0, 5'h04, 32'h0},
      '{1'b1, 5'h08, 32'h0},         '{1'b0, 5'h08, 32'h0}
    };

    // reset state
    tick(2);
    @(negedge clk);
    rst = 1'b0;
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_insvc", 32'(insvc), 32'd0);
    check("rst_vec", vec, 32'h100);
    rd_chk("rst_pend", 5'h00, 32'h0);
    rd_chk("rst_stat", 5'h10, 32'h0);

    // register table
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].data);
      else rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].data);
    end

    // single edge source, exact 4-edge latency
    wr(5'h04, 32'h01);
    wr(5'h08, 32'h01);
    @(negedge clk);
    src = 8'h01;
    @(posedge clk);
    @(negedge clk);
    src = '0;
    @(posedge clk);
    @(posedge clk);
    #1 check("lat_e3", 32'(intr), 32'd0);
    @(posedge clk);
    #1 check("lat_e4", 32'(intr), 32'd1);
    check("vec1", vec, 32'h104);
    rd_chk("pend1", 5'h00, 32'h01);
    rd_chk("claim1", 5'h0C, 32'd1);
    check("claim1_intr", 32'(intr), 32'd0);
    check("claim1_insvc", 32'(insvc), 32'd1);
    wr(5'h0C, 32'd1);
    check("cmp1_insvc", 32'(insvc), 32'd0);

    // two simultaneous edge sources, priority
    wr(5'h08, 32'h25);
    wr(5'h04, 32'h25);
    pulse(8'h24);
    tick(5);
    check("p2_intr", 32'(intr), 32'd1);
    check("p2_vec", vec, 32'h10C);
    rd_chk("p2_claim3", 5'h0C, 32'd3);
    rd_chk("p2_pend", 5'h00, 32'h20);
    rd_chk("p2_stat", 5'h10, 32'h23);
    wr(5'h0C, 32'd3);
    tick(1);
    check("p2_reintr", 32'(intr), 32'd1);
    check("p2_vec6", vec, 32'h118);
    rd_chk("p2_claim6", 5'h0C, 32'd6);
    wr(5'h0C, 32'd6);

    // level source re-request after complete
    wr(5'h08, 32'h00);
    wr(5'h04, 32'h02);
    @(negedge clk);
    src = 8'h02;
    tick(5);
    check("lv_intr", 32'(intr), 32'd1);
    check("lv_vec", vec, 32'h108);
    rd_chk("lv_claim", 5'h0C, 32'd2);
    tick(2);
    rd_chk("lv_pend_svc", 5'h00, 32'h00);
    wr(5'h0C, 32'd2);
    check("lv_e0", 32'(intr), 32'd0);
    tick(1);
    check("lv_e1", 32'(intr), 32'd0);
    tick(1);
    check("lv_e2", 32'(intr), 32'd1);
    @(negedge clk);
    src = '0;
    tick(6);
    check("lv_drop", 32'(intr), 32'd0);
    rd_chk("lv_claim_idle", 5'h0C, 32'd0);

    // edge set coincides with W1C: set wins
    wr(5'h08, 32'h01);
    wr(5'h04, 32'h00);
    @(negedge clk);
    src = 8'h01;
    @(posedge clk);
    @(negedge clk);
    src = '0;
    @(posedge clk);
    #1;
    wr(5'h00, 32'h01);
    rd_chk("w1c_race", 5'h00, 32'h01);
    wr(5'h00, 32'h01);
    rd_chk("w1c_clr", 5'h00, 32'h00);
    pulse(8'h01);
    tick(4);
    rd_chk("dis_pend", 5'h00, 32'h01);
    check("dis_intr", 32'(intr), 32'd0);
    wr(5'h04, 32'h01);
    tick(1);
    check("en_intr", 32'(intr), 32'd1);
    wr(5'h04, 32'h00);
    check("den_hold", 32'(intr), 32'd1);
    tick(1);
    check("den_intr", 32'(intr), 32'd0);
    rd_chk("den_claim", 5'h0C, 32'd0);
    wr(5'h00, 32'h01);

    // mismatched complete and claim in service
    wr(5'h08, 32'h09);
    wr(5'h04, 32'h01);
    pulse(8'h09);
    tick(5);
    check("s_intr", 32'(intr), 32'd1);
    rd_chk("s_claim", 5'h0C, 32'd1);
    rd_chk("s_pend", 5'h00, 32'h08);
    wr(5'h0C, 32'd4);
    rd_chk("s_stat", 5'h10, 32'h21);
    check("s_insvc", 32'(insvc), 32'd1);
    rd_chk("s_claim0", 5'h0C, 32'd0);
    rd_chk("s_pend2", 5'h00, 32'h08);

    // reset while in service
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("r_intr", 32'(intr), 32'd0);
    check("r_insvc", 32'(insvc), 32'd0);
    check("r_vec", vec, 32'h100);
    rd_chk("r_pend", 5'h00, 32'h0);
    rd_chk("r_en", 5'h04, 32'h0);
    rd_chk("r_edge", 5'h08, 32'h0);
    rd_chk("r_stat", 5'h10, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
